// File: rtl/stream_mux_nx1_pkg.sv
// Shared definitions for the N:1 stream multiplexer: lock states, mode codes, clog2.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package stream_mux_nx1_pkg;

    // Packet lock FSM states
    typedef enum logic {
        LK_IDLE   = 1'b0,
        LK_LOCKED = 1'b1
    } lock_state_e;

    // Selection mode codes carried on the mode input
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, minimum result 1 so a 2-input mux still gets a 1-bit index
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational channel picker: forced index or round-robin search upward from ptr with wrap.
// Latency: 0 cycles (pure combinational).
// Backpressure: none here; the caller qualifies the grant with its own load condition.
module stream_mux_nx1_rr_arbiter
    import stream_mux_nx1_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            force_en_i,
    input  logic [SELW-1:0] force_idx_i,
    output logic [N-1:0]    gnt_o,
    output logic [SELW-1:0] gnt_idx_o
);

    logic            found;
    logic [SELW:0]   cand;

    // Forced pick grants only the named channel (and only if it requests); otherwise
    // the first requester at or after ptr wins. Wrap is an explicit compare against N
    // so non-power-of-two channel counts never land on a phantom index.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        if (force_en_i) begin
            for (int i = 0; i < N; i++) begin
                if (force_idx_i == SELW'(i) && req_i[i]) begin
                    gnt_o[i]  = 1'b1;
                    gnt_idx_o = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = {1'b0, ptr_i} + (SELW+1)'(k);
                if (cand >= (SELW+1)'(N)) begin
                    cand = cand - (SELW+1)'(N);
                end
                if (!found && req_i[cand[SELW-1:0]]) begin
                    found                   = 1'b1;
                    gnt_o[cand[SELW-1:0]]   = 1'b1;
                    gnt_idx_o               = cand[SELW-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-input W-bit valid/ready stream mux, fixed or round-robin select; optional packet lock (STREAM_MUX_LOCK_EN).
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle while out_ready is high.
// Backpressure: in_ready = grant && (!out_valid || out_ready); output held stable while stalled.
module stream_mux_nx1
    import stream_mux_nx1_pkg::*;
#(
    parameter int W    = 16,
    parameter int N    = 4,
    parameter int SELW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SELW-1:0] out_ch
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic            out_last_q,  out_last_d;
    logic [SELW-1:0] out_ch_q,    out_ch_d;
    logic [SELW-1:0] ptr_q,       ptr_d;

    logic            load_ok;
    logic            locked;
    logic [SELW-1:0] lock_ch;
    logic            force_en;
    logic [SELW-1:0] force_idx;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] gnt_idx;
    logic            xfer;
    logic            ptr_adv;
    logic [W-1:0]    sel_data;
    logic            sel_last;

    assign load_ok = !out_valid_q || out_ready;

    // A held lock overrides both fixed select and round-robin
    assign force_en  = locked || (mode == MODE_FIXED);
    assign force_idx = locked ? lock_ch : sel;

    stream_mux_nx1_rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (ptr_q),
        .force_en_i  (force_en),
        .force_idx_i (force_idx),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx)
    );

    assign in_ready = gnt & {N{load_ok && !rst}};
    assign xfer     = |(in_valid & in_ready);

    // One-hot AND-OR select so only the granted channel's data reaches the register
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = in_data[i*W +: W];
                sel_last = in_last[i];
            end
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e     lock_q;
    logic [SELW-1:0] lock_ch_q;

    // Packet lock: a non-last beat pins the grant to its channel until the last beat moves
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= LK_IDLE;
            lock_ch_q <= '0;
        end else begin
            case (lock_q)
                LK_IDLE: begin
                    if (xfer && !sel_last) begin
                        lock_q    <= LK_LOCKED;
                        lock_ch_q <= gnt_idx;
                    end
                end
                LK_LOCKED: begin
                    if (xfer && sel_last) begin
                        lock_q <= LK_IDLE;
                    end
                end
                default: lock_q <= LK_IDLE;
            endcase
        end
    end

    assign locked  = (lock_q == LK_LOCKED);
    assign lock_ch = lock_ch_q;
    // Fairness is per packet: only the closing beat moves the pointer
    assign ptr_adv = xfer && sel_last;
`else
    assign locked  = 1'b0;
    assign lock_ch = '0;
    assign ptr_adv = xfer;
`endif

    // Next state for the output stage and the round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_ch_d    = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (ptr_adv && mode == MODE_RR) begin
            ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);
        end
    end

    // Output register and pointer; reset drops any in-flight beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
